jtag_mem_bridge: RTL

//  Consumer of the 32-bit JTAG data register (reg3) update strobe. Decodes the shifted-in command word.

---
 rtl/jtag_mem_bridge.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/jtag_mem_bridge.sv
// JTAG reg3 command decoder driving one req/gnt/rvalid memory transaction per update.
// Optional: JTAG_MEM_BRIDGE_AUTOINC_EN turns op 11 into READ_NEXT (last address + 1).
module jtag_mem_bridge #(
   parameter int CMD_WIDTH  = 32,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  update_i,
   input  logic [CMD_WIDTH-1:0]  cmd_i,
   output logic [CMD_WIDTH-1:0]  status_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RWAIT} state_t;

   state_t                state_q, state_d;
   logic                  upd_q;
   logic [7:0]            cnt_q, cnt_d;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  ovr_q, tmo_q;

   logic [1:0]            op;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  fire, busy, cnt_hit;
   logic                  is_rw, is_rd, is_cmd;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  accept, clear, ovr_set;
   logic                  tmo_set, rd_cap;

   assign op        = cmd_i[CMD_WIDTH-1 -: 2];
   assign cmd_addr  = cmd_i[CMD_WIDTH-3 -: ADDR_WIDTH];
   assign cmd_wdata = cmd_i[DATA_WIDTH-1:0];
   assign fire      = update_i & ~upd_q;
   assign busy      = (state_q != IDLE);
   assign cnt_hit   = (cnt_q == TMO_LAST);

`ifdef JTAG_MEM_BRIDGE_AUTOINC_EN
   logic [ADDR_WIDTH-1:0] last_q;

   assign is_rw    = (op != 2'b00);
   assign is_rd    = op[1];
   assign is_cmd   = 1'b1;
   assign req_addr = (op == 2'b11) ? last_q + 1'b1 : cmd_addr;

   // Remember the address of every accepted bus command for READ_NEXT.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= '0;
      end else if (accept) begin
         last_q <= req_addr;
      end
   end
`else
   assign is_rw    = (op == 2'b01) | (op == 2'b10);
   assign is_rd    = (op == 2'b10);
   assign is_cmd   = (op != 2'b11);
   assign req_addr = cmd_addr;
`endif

   assign accept  = fire & ~busy & is_rw;
   assign clear   = fire & ~busy & (op == 2'b00);
   assign ovr_set = fire & busy & is_cmd;

   // Next state, timeout and read-capture decisions.
   always_comb begin
      state_d = state_q;
      tmo_set = 1'b0;
      rd_cap  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = REQ;
         end
         REQ: begin
            if (mem_gnt_i) begin
               state_d = we_q ? IDLE : RWAIT;
            end else if (cnt_hit) begin
               tmo_set = 1'b1;
               state_d = IDLE;
            end
         end
         RWAIT: begin
            if (mem_rvalid_i) begin
               rd_cap  = 1'b1;
               state_d = IDLE;
            end else if (cnt_hit) begin
               tmo_set = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Wait counter restarts on every state change and runs while waiting.
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q && state_q != IDLE) cnt_d = cnt_q + 8'd1;
   end

   // State, counter and update edge detector.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         upd_q   <= update_i;
      end
   end

   // Bus command latched at acceptance and held until the next one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= ~is_rd;
         addr_q  <= req_addr;
         wdata_q <= cmd_wdata;
      end
   end

   // Read data and sticky error flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         if (rd_cap) rdata_q <= mem_rdata_i;
         if (clear) begin
            ovr_q <= 1'b0;
            tmo_q <= 1'b0;
         end else begin
            if (ovr_set) ovr_q <= 1'b1;
            if (tmo_set) tmo_q <= 1'b1;
         end
      end
   end

   assign mem_req_o   = (state_q == REQ);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   // Status word assembled straight from registered state.
   always_comb begin
      status_o                 = '0;
      status_o[CMD_WIDTH-1]    = busy;
      status_o[CMD_WIDTH-2]    = ovr_q;
      status_o[CMD_WIDTH-3]    = tmo_q;
      status_o[DATA_WIDTH-1:0] = rdata_q;
   end

endmodule
